// File: rtl/burst_fifo_ctrl.sv
// DDR read-burst FIFO controller: burst request FSM, RAM write/read pointers, 2-entry output buffer.
// Optional protocol checking (sticky error) is enabled with `define BURST_FIFO_CHECK_EN.
module burst_fifo_ctrl #(
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  output logic        burst_req,
  input  logic        burst_ack,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        ram_w_en,
  output logic [5:0]  ram_w_addr,
  output logic [63:0] ram_w_data,
  output logic        ram_r_en,
  output logic [5:0]  ram_r_addr,
  input  logic [63:0] ram_r_data,
  output logic [6:0]  level,
  output logic        error
);

  localparam logic [6:0] FULL_LVL  = 7'(DEPTH);
  localparam logic [6:0] BURST_W   = 7'(BURST_LEN);
  localparam logic [5:0] BEAT_LAST = 6'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [6:0]  wptr_r;
  logic [6:0]  rptr_r;
  logic [5:0]  beat_r;
  logic        discard_r;
  logic        inflight_r;
  logic [1:0]  bcnt_r;
  logic [63:0] buf0_r;
  logic [63:0] buf1_r;

  logic [6:0]  level_s;
  logic [6:0]  free_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_s;
  logic [2:0]  occ_s;
  logic        rd_s;
  logic        wr_s;
  logic        beat_s;
  logic        last_beat_s;
  logic [1:0]  bcnt_s;
  logic [63:0] buf0_s;
  logic [63:0] buf1_s;

  assign level_s     = wptr_r - rptr_r;
  assign free_s      = FULL_LVL - level_s;
  assign full_s      = (level_s == FULL_LVL);
  assign empty_s     = (level_s == 7'd0);
  assign out_valid   = (bcnt_r != 2'd0);
  assign pop_s       = out_valid && out_ready;
  assign push_s      = inflight_r && !flush;
  assign occ_s       = {1'b0, bcnt_r} + {2'b00, inflight_r};
  // A read may be issued only if its returning word is guaranteed a buffer slot.
  assign rd_s        = !flush && !empty_s && ((occ_s - {2'b00, pop_s}) < 3'd2);
  assign beat_s      = in_valid && (state_r == WAIT);
  assign last_beat_s = beat_s && (beat_r == BEAT_LAST);
  assign wr_s        = beat_s && !full_s && !flush && !discard_r;

  assign level      = level_s;
  assign out_data   = buf0_r;
  assign ram_w_en   = wr_s;
  assign ram_w_addr = wptr_r[5:0];
  assign ram_w_data = wr_s ? in_data : 64'd0;
  assign ram_r_en   = rd_s;
  assign ram_r_addr = rptr_r[5:0];

  // Burst FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst FSM next-state logic; flush holds IDLE but never cancels a pending request.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!flush && (free_s >= BURST_W)) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (burst_ack) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (last_beat_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Burst FSM output decode.
  always_comb begin
    burst_req = 1'b0;
    case (state_r)
      REQ:     burst_req = 1'b1;
      IDLE:    burst_req = 1'b0;
      WAIT:    burst_req = 1'b0;
      default: burst_req = 1'b0;
    endcase
  end

  // Beat counter and discard flag for a burst interrupted by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_r    <= 6'd0;
      discard_r <= 1'b0;
    end else begin
      if (last_beat_s || (state_r != WAIT)) begin
        beat_r <= 6'd0;
      end else if (beat_s) begin
        beat_r <= beat_r + 6'd1;
      end
      if (state_s != WAIT) begin
        discard_r <= 1'b0;
      end else if (flush && (state_r == WAIT)) begin
        discard_r <= 1'b1;
      end
    end
  end

  // RAM pointers and in-flight read flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r     <= 7'd0;
      rptr_r     <= 7'd0;
      inflight_r <= 1'b0;
    end else if (flush) begin
      wptr_r     <= 7'd0;
      rptr_r     <= 7'd0;
      inflight_r <= 1'b0;
    end else begin
      wptr_r     <= wptr_r + {6'd0, wr_s};
      rptr_r     <= rptr_r + {6'd0, rd_s};
      inflight_r <= rd_s;
    end
  end

  // Output buffer next state: head is buf0, returning RAM data fills the first free slot.
  always_comb begin
    buf0_s = buf0_r;
    buf1_s = buf1_r;
    bcnt_s = bcnt_r;
    if (flush) begin
      buf0_s = 64'd0;
      buf1_s = 64'd0;
      bcnt_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (bcnt_r == 2'd0) begin
            buf0_s = ram_r_data;
          end else begin
            buf1_s = ram_r_data;
          end
          bcnt_s = bcnt_r + 2'd1;
        end
        2'b01: begin
          buf0_s = buf1_r;
          bcnt_s = bcnt_r - 2'd1;
        end
        2'b11: begin
          if (bcnt_r == 2'd2) begin
            buf0_s = buf1_r;
            buf1_s = ram_r_data;
          end else begin
            buf0_s = ram_r_data;
          end
        end
        default: begin
          bcnt_s = bcnt_r;
        end
      endcase
    end
  end

  // Output buffer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf0_r <= 64'd0;
      buf1_r <= 64'd0;
      bcnt_r <= 2'd0;
    end else begin
      buf0_r <= buf0_s;
      buf1_r <= buf1_s;
      bcnt_r <= bcnt_s;
    end
  end

`ifdef BURST_FIFO_CHECK_EN
  logic error_r;

  // Sticky protocol error: a word outside a burst window or into a full RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_r <= 1'b0;
    end else if (in_valid && ((state_r != WAIT) || full_s)) begin
      error_r <= 1'b1;
    end
  end

  assign error = error_r;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_burst_fifo_ctrl.sv
// Scoreboard bench for burst_fifo_ctrl: directed bursts, fill, backpressure, flush, protocol error, async reset.
module tb_burst_fifo_ctrl;

  localparam int BL = 8;
`ifdef BURST_FIFO_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        burst_req;
  logic        burst_ack = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        ram_w_en;
  logic [5:0]  ram_w_addr;
  logic [63:0] ram_w_data;
  logic        ram_r_en;
  logic [5:0]  ram_r_addr;
  logic [63:0] ram_r_data = 64'd0;
  logic [6:0]  level;
  logic        error;

  burst_fifo_ctrl #(.BURST_LEN(BL), .DEPTH(64)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .burst_req(burst_req), .burst_ack(burst_ack),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .level(level), .error(error)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [0:63];
  always @(posedge clock) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q [$];
  int          wq [$];
  bit          lat_en = 1'b0;
  bit          toggle_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Record write cycles for the latency check of the first burst.
  always @(negedge clock) begin
    if (reset_n && lat_en && ram_w_en) wq.push_back(cyc);
  end

  // Monitor: every accepted output word is compared against the scoreboard head.
  always @(negedge clock) begin : mon_out
    logic [63:0] e;
    int          w;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h expected no word (cycle %0d)", out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
        if (lat_en) begin
          if (wq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL latency: got output %0h with no recorded write", out_data);
          end else begin
            w = wq.pop_front();
            chk("latency", 64'(cyc - w), 64'd3);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (toggle_en) out_ready = ~out_ready;
  endtask

  task automatic wait_req(input string name);
    int t = 0;
    while (!burst_req && t < 100) begin
      step();
      t++;
    end
    chk(name, 64'(burst_req), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      step();
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_burst_req"}, 64'(burst_req), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_ram_w_en"}, 64'(ram_w_en), 64'd0);
    chk({tag, "_ram_w_data"}, ram_w_data, 64'd0);
    chk({tag, "_ram_r_en"}, 64'(ram_r_en), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  // mode 0: normal, 1: flush after k words, 2: async reset after k words, 3: stray word after burst
  task automatic do_burst(input logic [63:0] base, input int mode, input int k);
    wait_req("burst_req");
    burst_ack = 1'b1;
    step();
    burst_ack = 1'b0;
    for (int i = 0; i < BL; i++) begin
      if (mode == 1 && i == k) begin
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("out_valid_after_flush", 64'(out_valid), 64'd0);
      end
      in_valid = 1'b1;
      in_data = base + 64'(i);
      if (mode == 2 && i == k) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        in_valid = 1'b0;
        return;
      end
      if (mode == 0 || mode == 3) exp_q.push_back(base + 64'(i));
      step();
    end
    in_valid = 1'b0;
    if (mode == 3) begin
      in_valid = 1'b1;
      in_data = base + 64'h100;
      step();
      in_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
    chk("req_after_reset", 64'(burst_req), 64'd1);

    // Single burst, latency and re-request.
    out_ready = 1'b1;
    lat_en = 1'b1;
    do_burst(64'h0, 0, 0);
    wait_req("req_reassert");
    drain();
    lat_en = 1'b0;
    wq.delete();

    // Fill with consumer stalled.
    out_ready = 1'b0;
    for (int b = 0; b < 8; b++) do_burst(64'h1000 + 64'(b * BL), 0, 0);
    repeat (10) step();
    chk("fill_level", 64'(level), 64'd62);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (burst_req) seen = 1'b1;
    end
    chk("fill_no_9th_req", 64'(seen), 64'd0);
    out_ready = 1'b1;
    drain();

    // Backpressure toggling every cycle.
    toggle_en = 1'b1;
    for (int b = 0; b < 3; b++) do_burst(64'h2000 + 64'(b * BL), 0, 0);
    toggle_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Flush mid-burst, next burst comes out first.
    out_ready = 1'b0;
    do_burst(64'h3000, 1, 3);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    do_burst(64'h4000, 0, 0);
    drain();

    // Stray word right after a burst (FSM in IDLE).
    out_ready = 1'b0;
    do_burst(64'h5000, 3, 0);
    chk("stray_level", 64'(level), 64'd6);
    chk("stray_error", 64'(error), 64'(EXP_ERR));
    repeat (3) step();
    chk("stray_error_sticky", 64'(error), 64'(EXP_ERR));
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream, then restart.
    out_ready = 1'b0;
    do_burst(64'h6000, 2, 4);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("req_after_rst_release", 64'(burst_req), 64'd1);
    out_ready = 1'b1;
    do_burst(64'h7000, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_fifo_ctrl.md
# burst_fifo_ctrl

Controller for one 64-entry × 64-bit dual-port RAM used as a DDR read-burst FIFO. It sits between the DDR burst reader and the 64-bit consumer (tile/sprite fetch).
- **Upstream:** it issues fixed-length burst requests only when the RAM has space for a whole burst, then writes the returned words into the RAM.
- **Downstream:** it reads the RAM (registered address, one-cycle read latency) through a 2-entry output buffer. This presents a valid/ready stream at one word per cycle.

## Interface
Parameters:
- `BURST_LEN`, 8 — words per burst; power of two, 1..32.
- `DEPTH`, 64 — RAM entries; fixed by the attached RAM.

Ports:
- `clock` in 1 — sole clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — synchronous clear of FIFO contents.
- `burst_req` out 1 — burst request to the DDR reader.
- `burst_ack` in 1 — request accepted.
- `in_valid` in 1 — burst data word valid; there is no backpressure.
- `in_data` in 64 — burst data.
- `out_valid` out 1 — output word valid.
- `out_ready` in 1 — consumer accepts.
- `out_data` out 64 — output word.
- `ram_w_en` out 1, `ram_w_addr` out 6, `ram_w_data` out 64 — RAM write port.
- `ram_r_en` out 1, `ram_r_addr` out 6 — RAM read port.
- `ram_r_data` in 64 — RAM read data. It is valid the cycle after `ram_r_en`.
- `level` out 7 — RAM occupancy, 0..64.
- `error` out 1 — sticky protocol error; present only with the macro (see Configuration).

## Operation
**Pointers**
- 7-bit write and read pointers; the RAM address is `ptr[5:0]`.
- `level = wptr - rptr` (mod 128). Full when `level == 64`; empty when `level == 0`.

**Burst FSM: IDLE → REQ → WAIT → IDLE**
- IDLE: go to REQ when `64 - level >= BURST_LEN`.
- REQ: `burst_req = 1`. Go to WAIT on `burst_ack`.
- WAIT: count `in_valid` words. Return to IDLE after the `BURST_LEN`th word.
  - Space was reserved before the request, so a word arriving in WAIT never finds the RAM full.
- Reserved space: IDLE's free-space test is evaluated against `level` only. No new request is made until the current burst completes.

**Write path**
- `ram_w_en = in_valid && state == WAIT && !full && !flush`.
- Address is `wptr`; data is `in_data`. `wptr` increments on each write.
- `in_valid` in any other state, or when full, is dropped.

**Read path**
- Let `occ` = output-buffer entries (0..2) + in-flight read (0..1).
- Issue a read (`ram_r_en = 1`, `ram_r_addr = rptr`, `rptr++`) when the RAM is not empty and `occ - (out_valid && out_ready) < 2`.
- Returned `ram_r_data` is pushed into the output buffer the next cycle.
- The output buffer is a 2-entry FIFO. `out_data` is always its head.
- Read and write never touch the same address in the same cycle: reads target only entries written in earlier cycles.

**Flush**
- Clears `wptr`, `rptr`, the output buffer and the in-flight flag in one cycle.
- FSM:
  - REQ stays in REQ; the request is not withdrawn.
  - WAIT continues counting and discards the remaining burst words, then goes to IDLE.
  - IDLE stays IDLE.

**Reset**
- Every output is 0 and every pointer and counter is 0.
- The FSM is in IDLE and the output buffer is empty.

## Timing
- `burst_req` rises in the cycle after reset release: the RAM is empty.
- A word written in cycle N is read (`ram_r_en`) no earlier than N+1. It lands in the output buffer at the end of N+2 and shows `out_valid = 1` in N+3.
- Sustained throughput is 1 word/cycle with `out_ready` held high.
- With `out_ready` low, at most 2 words are held downstream of the RAM and no read is issued.
- A read issue and a write in the same cycle both take effect. `level` is unchanged when both happen.
- Flush overrides a same-cycle read or write. `out_valid = 0` in the cycle after `flush`.

## Configuration
Macro: `BURST_FIFO_CHECK_EN`.
- **Defined:** `error` is sticky-set by either condition below, and cleared only by reset. The offending word is dropped.
  - `in_valid` outside WAIT.
  - `in_valid` while full.
- **Undefined:** `error` is tied to 0 and the checking logic is removed. Such words are still dropped.

## Test plan
- **Reset then single burst.** Drive `burst_ack` at cycle 2, then 8 back-to-back words 0..7, with `out_ready = 1`.
  - Required: words 0..7 appear in order, the first 3 cycles after its write.
  - Required: `burst_req` re-asserts after the burst completes.
- **Fill.** `out_ready = 0`, acknowledge every request.
  - Required: exactly 8 bursts are requested.
  - Required: after the RAM reads that fill the output buffer, `level` settles at 62 and the buffer holds 2 words.
  - Required: no further `burst_req` is made until `out_ready` rises.
- **Backpressure toggle.** Toggle `out_ready` every cycle during a full stream.
  - Required: no word is lost or duplicated, and the sequence is monotonic.
- **Flush mid-burst.** Flush after 3 of 8 words.
  - Required: the remaining 5 words are discarded and `level = 0`.
  - Required: the next burst's data is output first.
- **Protocol error.** With `BURST_FIFO_CHECK_EN` defined, assert `in_valid` in IDLE.
  - Required: `error = 1` and stays set; the word is not written; `level` is unchanged.
- **Async reset mid-stream.** Drop `reset_n` mid-stream.
  - Required: every output is 0 immediately, and the FSM restarts with `burst_req` after release.
